// File: rtl/audio_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : audio_axi_lite_arbiter
// Description : Two-requester round-robin arbiter and AXI4-Lite master
//               sequencer for the 4-register audio-to-AXI slave. Each
//               requester issues single-word reads or writes over a level
//               req / one-cycle ack port; one command is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_axi_lite_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                      m00_axi_aclk,
    input  logic                      m00_axi_aresetn,

    // Requester command ports, requester i in slice i
    input  logic [1:0]                req,
    input  logic [1:0]                req_we,
    input  logic [2*ADDR_W-1:0]       req_addr,
    input  logic [2*DATA_W-1:0]       req_wdata,
    input  logic [2*(DATA_W/8)-1:0]   req_wstrb,
    output logic [1:0]                ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                resp,

    // AXI4-Lite master: write address
    output logic [ADDR_W-1:0]         m00_axi_awaddr,
    output logic [2:0]                m00_axi_awprot,
    output logic                      m00_axi_awvalid,
    input  logic                      m00_axi_awready,
    // write data
    output logic [DATA_W-1:0]         m00_axi_wdata,
    output logic [(DATA_W/8)-1:0]     m00_axi_wstrb,
    output logic                      m00_axi_wvalid,
    input  logic                      m00_axi_wready,
    // write response
    input  logic [1:0]                m00_axi_bresp,
    input  logic                      m00_axi_bvalid,
    output logic                      m00_axi_bready,
    // read address
    output logic [ADDR_W-1:0]         m00_axi_araddr,
    output logic [2:0]                m00_axi_arprot,
    output logic                      m00_axi_arvalid,
    input  logic                      m00_axi_arready,
    // read data
    input  logic [DATA_W-1:0]         m00_axi_rdata,
    input  logic [1:0]                m00_axi_rresp,
    input  logic                      m00_axi_rvalid,
    output logic                      m00_axi_rready
);

    // Sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;  // AW and W channels in flight
    localparam logic [2:0] ST_WB   = 3'd2;  // waiting for write response
    localparam logic [2:0] ST_RA   = 3'd3;  // AR channel in flight
    localparam logic [2:0] ST_RD   = 3'd4;  // waiting for read data
    localparam logic [2:0] ST_DONE = 3'd5;  // ack pulse to granted requester

    // Registers are word-addressed on the slave; byte offset is dropped
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [2:0]              state_q,      state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q,      grant_d;
    logic [ADDR_W-1:0]       addr_q,       addr_d;
    logic [DATA_W-1:0]       wdata_q,      wdata_d;
    logic [(DATA_W/8)-1:0]   wstrb_q,      wstrb_d;
    logic                    aw_done_q,    aw_done_d;
    logic                    w_done_q,     w_done_d;
    logic [DATA_W-1:0]       rdata_q,      rdata_d;
    logic [1:0]              resp_q,       resp_d;

    // Arbitration and selected-requester command fields
    logic                    sel_grant;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic [(DATA_W/8)-1:0]   sel_wstrb;
    logic                    aw_hs;
    logic                    w_hs;

    // Round-robin pick: the requester other than last_grant wins if it asks,
    // otherwise whichever single requester is active keeps the grant.
    always_comb begin
        sel_grant = last_grant_q;
        if (req[~last_grant_q]) begin
            sel_grant = ~last_grant_q;
        end
        sel_we    = sel_grant ? req_we[1] : req_we[0];
        sel_addr  = sel_grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata = sel_grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        sel_wstrb = sel_grant ? req_wstrb[2*(DATA_W/8)-1:DATA_W/8]
                              : req_wstrb[(DATA_W/8)-1:0];
    end

    // AXI handshakes seen this cycle on the two write channels
    always_comb begin
        aw_hs = m00_axi_awvalid & m00_axi_awready;
        w_hs  = m00_axi_wvalid  & m00_axi_wready;
    end

    // State register and command/response holding registers
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

    // Next-state logic: grant, command capture and channel progress
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d      = sel_grant;
                    last_grant_d = sel_grant;
                    addr_d       = sel_addr & WORD_MASK;
                    wdata_d      = sel_wdata;
                    wstrb_d      = sel_wstrb;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = sel_we ? ST_WR : ST_RA;
                end
            end
            ST_WR: begin
                // Each channel completes on its own; leave once both are done,
                // regardless of order or same-cycle completion.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (m00_axi_bvalid) begin
                    resp_d  = m00_axi_bresp;
                    state_d = ST_DONE;
                end
            end
            ST_RA: begin
                if (m00_axi_arready) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (m00_axi_rvalid) begin
                    rdata_d = m00_axi_rdata;
                    resp_d  = m00_axi_rresp;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: AXI valids/readies and ack come straight from state
    always_comb begin
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        ack             = 2'b00;

        case (state_q)
            ST_WR: begin
                m00_axi_awvalid = ~aw_done_q;
                m00_axi_wvalid  = ~w_done_q;
            end
            ST_WB:   m00_axi_bready  = 1'b1;
            ST_RA:   m00_axi_arvalid = 1'b1;
            ST_RD:   m00_axi_rready  = 1'b1;
            ST_DONE: ack = grant_q ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    // Address/data always come from the registered command copy
    always_comb begin
        m00_axi_awaddr = addr_q;
        m00_axi_araddr = addr_q;
        m00_axi_wdata  = wdata_q;
        m00_axi_wstrb  = wstrb_q;
        m00_axi_awprot = 3'b000;
        m00_axi_arprot = 3'b000;
        rdata          = rdata_q;
        resp           = resp_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_axi_lite_arbiter
// Description : Scoreboard bench for audio_axi_lite_arbiter with a small
//               AXI4-Lite slave model (4 registers, configurable stalls,
//               error response and hung read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_axi_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, req_we;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic [1:0]  resp;

    logic [3:0]  m00_axi_awaddr, m00_axi_araddr;
    logic [2:0]  m00_axi_awprot, m00_axi_arprot;
    logic        m00_axi_awvalid, m00_axi_awready;
    logic [31:0] m00_axi_wdata;
    logic [3:0]  m00_axi_wstrb;
    logic        m00_axi_wvalid, m00_axi_wready;
    logic [1:0]  m00_axi_bresp;
    logic        m00_axi_bvalid, m00_axi_bready;
    logic        m00_axi_arvalid, m00_axi_arready;
    logic [31:0] m00_axi_rdata;
    logic [1:0]  m00_axi_rresp;
    logic        m00_axi_rvalid, m00_axi_rready;

    always #5 clk = ~clk;

    audio_axi_lite_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .ack(ack), .rdata(rdata), .resp(resp),
        .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awprot(m00_axi_awprot),
        .m00_axi_awvalid(m00_axi_awvalid), .m00_axi_awready(m00_axi_awready),
        .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb),
        .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m00_axi_wready),
        .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid),
        .m00_axi_bready(m00_axi_bready),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arprot(m00_axi_arprot),
        .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
        .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready)
    );

    // ---------------- slave model ----------------
    int          aw_stall = 0, w_stall = 0;   // cycles of ready-low per command
    logic        err_en = 1'b0;               // answer writes with SLVERR
    logic        r_hang = 1'b0;               // never return read data
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got;
    logic [3:0]  aw_lat, last_awaddr, last_araddr;
    logic [31:0] w_dat;
    logic [3:0]  w_stb;
    logic [31:0] mem [4];
    logic        aw_hs, w_hs, aw_now, w_now;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_stb;

    assign m00_axi_awready = (aw_cnt >= aw_stall);
    assign m00_axi_wready  = (w_cnt >= w_stall);
    assign m00_axi_arready = 1'b1;
    assign aw_hs   = m00_axi_awvalid & m00_axi_awready;
    assign w_hs    = m00_axi_wvalid & m00_axi_wready;
    assign aw_now  = aw_got | aw_hs;
    assign w_now   = w_got | w_hs;
    assign wr_addr = aw_got ? aw_lat : m00_axi_awaddr;
    assign wr_data = w_got ? w_dat : m00_axi_wdata;
    assign wr_stb  = w_got ? w_stb : m00_axi_wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_lat <= '0; w_dat <= '0; w_stb <= '0;
            last_awaddr <= '0; last_araddr <= '0;
            m00_axi_bvalid <= 1'b0; m00_axi_bresp <= '0;
            m00_axi_rvalid <= 1'b0; m00_axi_rdata <= '0; m00_axi_rresp <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1; aw_lat <= m00_axi_awaddr;
                last_awaddr <= m00_axi_awaddr; aw_cnt <= 0;
            end else if (m00_axi_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_got <= 1'b1; w_dat <= m00_axi_wdata; w_stb <= m00_axi_wstrb; w_cnt <= 0;
            end else if (m00_axi_wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_now && w_now && !m00_axi_bvalid) begin
                if (!err_en) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_stb[b]) mem[wr_addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
                m00_axi_bresp  <= err_en ? 2'b10 : 2'b00;
                m00_axi_bvalid <= 1'b1;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (m00_axi_bvalid && m00_axi_bready) m00_axi_bvalid <= 1'b0;
            if (m00_axi_arvalid && m00_axi_arready) begin
                last_araddr <= m00_axi_araddr;
                if (!r_hang) begin
                    m00_axi_rvalid <= 1'b1;
                    m00_axi_rdata  <= mem[m00_axi_araddr[3:2]];
                    m00_axi_rresp  <= 2'b00;
                end
            end
            if (m00_axi_rvalid && m00_axi_rready) m00_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;     // 0 = latency not checked
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    exp_t sb_q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   n_awv = 0, n_wv = 0, n_bhs = 0, n_ack = 0;
    int   start_cyc [2];
    logic [1:0] req_prev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic void push(input logic id, input logic we, input logic [31:0] rd,
                                 input logic [1:0] rs, input int lat);
        exp_t e;
        e.id = id; e.we = we; e.rdata = rd; e.resp = rs; e.lat = lat;
        sb_q.push_back(e);
    endfunction

    function automatic cmd_t mk(input logic we, input logic [3:0] addr,
                                input logic [31:0] wd, input logic [3:0] ws);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wd; c.wstrb = ws;
        return c;
    endfunction

    // Monitor: counts channel activity and checks every ack against the queue
    initial begin : monitor
        exp_t e;
        req_prev = 2'b00;
        start_cyc[0] = 0; start_cyc[1] = 0;
        forever begin
            @(negedge clk);
            n_awv += int'(m00_axi_awvalid);
            n_wv  += int'(m00_axi_wvalid);
            n_bhs += int'(m00_axi_bvalid & m00_axi_bready);
            for (int i = 0; i < 2; i++)
                if (req[i] && !req_prev[i]) start_cyc[i] = cyc;
            req_prev = req;
            if (ack != 2'b00) begin
                n_ack++;
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_ack: got ack=%b, expected no ack", ack);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_id", {62'd0, ack}, e.id ? 64'd2 : 64'd1);
                    check("resp", {62'd0, resp}, {62'd0, e.resp});
                    if (!e.we) check("rdata", {32'd0, rdata}, {32'd0, e.rdata});
                    if (e.lat > 0)
                        check("latency", 64'(cyc - start_cyc[e.id]), 64'(e.lat));
                end
            end
        end
    end

    // Drive commands for requesters in mask; each holds until its own ack
    task automatic issue(input logic [1:0] mask, input cmd_t c0, input cmd_t c1);
        logic [1:0] pending, got;
        req_we    = {c1.we, c0.we};
        req_addr  = {c1.addr, c0.addr};
        req_wdata = {c1.wdata, c0.wdata};
        req_wstrb = {c1.wstrb, c0.wstrb};
        req       = mask;
        pending   = mask;
        for (int k = 0; k < 300 && pending != 2'b00; k++) begin
            @(negedge clk);
            got = ack & pending;
            @(posedge clk); #1;
            req     = req & ~got;
            pending = pending & ~got;
        end
        check("ack_timeout", {62'd0, pending}, 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        cmd_t nul;
        int   a0, w0, b0, k0;
        nul = mk(1'b0, 4'h0, 32'h0, 4'h0);
        rst_n = 1'b0; req = 2'b00; req_we = 2'b00; req_addr = '0;
        req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_valids", {59'd0, m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready,
                             m00_axi_arvalid, m00_axi_rready}, 64'd0);
        check("rst_ack", {62'd0, ack}, 64'd0);
        check("rst_rdata_resp", {30'd0, rdata, resp}, 64'd0);
        check("rst_addr_data", {14'd0, m00_axi_awaddr, m00_axi_araddr, m00_axi_wdata,
                                m00_axi_wstrb, m00_axi_awprot, m00_axi_arprot}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous after reset: requester 0 first, then 1
        push(1'b0, 1'b1, 32'h0, 2'b00, 0);
        push(1'b1, 1'b1, 32'h0, 2'b00, 0);
        issue(2'b11, mk(1'b1, 4'h0, 32'h11110000, 4'hF), mk(1'b1, 4'h8, 32'h22220008, 4'hF));

        // Requester 0 write, zero wait states
        a0 = n_awv; w0 = n_wv;
        push(1'b0, 1'b1, 32'h0, 2'b00, 3);
        issue(2'b01, mk(1'b1, 4'h4, 32'hABCD0001, 4'hF), nul);
        check("wr0_awaddr", {60'd0, last_awaddr}, 64'h4);
        check("wr0_aw_cycles", 64'(n_awv - a0), 64'd1);
        check("wr0_w_cycles", 64'(n_wv - w0), 64'd1);

        // Requester 1 reads it back
        push(1'b1, 1'b0, 32'hABCD0001, 2'b00, 3);
        issue(2'b10, nul, mk(1'b0, 4'h4, 32'h0, 4'h0));
        check("rd1_araddr", {60'd0, last_araddr}, 64'h4);

        // Requester 0 alone, so last_grant becomes 0
        push(1'b0, 1'b0, 32'h11110000, 2'b00, 3);
        issue(2'b01, mk(1'b0, 4'h0, 32'h0, 4'h0), nul);

        // Repeated simultaneous request: now requester 1 goes first
        push(1'b1, 1'b0, 32'h22220008, 2'b00, 0);
        push(1'b0, 1'b0, 32'hABCD0001, 2'b00, 0);
        issue(2'b11, mk(1'b0, 4'h4, 32'h0, 4'h0), mk(1'b0, 4'h8, 32'h0, 4'h0));

        // AW stalled 3 cycles, W immediate
        aw_stall = 3;
        a0 = n_awv; w0 = n_wv; b0 = n_bhs; k0 = n_ack;
        push(1'b0, 1'b1, 32'h0, 2'b00, 0);
        issue(2'b01, mk(1'b1, 4'hC, 32'h33333333, 4'hF), nul);
        aw_stall = 0;
        check("split_aw_cycles", 64'(n_awv - a0), 64'd4);
        check("split_w_cycles", 64'(n_wv - w0), 64'd1);
        check("split_b_hs", 64'(n_bhs - b0), 64'd1);
        check("split_acks", 64'(n_ack - k0), 64'd1);

        // Mirrored: W stalled 3 cycles, AW immediate, low half strobes
        w_stall = 3;
        a0 = n_awv; w0 = n_wv; b0 = n_bhs; k0 = n_ack;
        push(1'b0, 1'b1, 32'h0, 2'b00, 0);
        issue(2'b01, mk(1'b1, 4'hC, 32'h44444444, 4'h3), nul);
        w_stall = 0;
        check("mirror_aw_cycles", 64'(n_awv - a0), 64'd1);
        check("mirror_w_cycles", 64'(n_wv - w0), 64'd4);
        check("mirror_b_hs", 64'(n_bhs - b0), 64'd1);
        check("mirror_acks", 64'(n_ack - k0), 64'd1);
        push(1'b1, 1'b0, 32'h33334444, 2'b00, 3);
        issue(2'b10, nul, mk(1'b0, 4'hC, 32'h0, 4'h0));

        // Slave error on unaligned address
        err_en = 1'b1;
        push(1'b1, 1'b1, 32'h0, 2'b10, 3);
        issue(2'b10, nul, mk(1'b1, 4'h7, 32'h55555555, 4'hF));
        err_en = 1'b0;
        check("err_awaddr_aligned", {60'd0, last_awaddr}, 64'h4);

        // Reset while waiting for read data
        r_hang = 1'b1;
        req_we = 2'b00; req_addr = 8'h00; req = 2'b10;
        for (int k = 0; k < 20 && !m00_axi_rready; k++) @(negedge clk);
        check("reached_rd", {63'd0, m00_axi_rready}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valids", {59'd0, m00_axi_arvalid, m00_axi_rready, m00_axi_awvalid,
                                 m00_axi_wvalid, m00_axi_bready}, 64'd0);
        check("rst_mid_ack", {62'd0, ack}, 64'd0);
        req = 2'b00; r_hang = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        push(1'b0, 1'b1, 32'h0, 2'b00, 3);
        issue(2'b01, mk(1'b1, 4'h8, 32'hDEAD0011, 4'hF), nul);
        push(1'b0, 1'b0, 32'hDEAD0011, 2'b00, 3);
        issue(2'b01, mk(1'b0, 4'h8, 32'h0, 4'h0), nul);

        repeat (5) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
